// File: rtl/wb_commit_arbiter_if.sv
// Writeback bundle between the ALU/MUL result producers, the issue-side MUL
// credit handshake, the register-file write port and the scoreboard release.
// Optional perf counter outputs exist only with WB_PERF_COUNTERS_EN defined.
interface wb_commit_arbiter_if;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } alu_wb_inf_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } mul_wb_inf_t;

    // Result producers
    logic        alu_valid;
    alu_wb_inf_t alu_wb_inf;
    logic        mul_valid;
    mul_wb_inf_t mul_wb_inf;

    // Issue-side MUL credit handshake
    logic        ix_mul_ready;
    logic        ix_mul_issue;

    // Register-file write port
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Scoreboard release
    logic        wb_retire_valid;
    logic [4:0]  wb_retire_rd;

`ifdef WB_PERF_COUNTERS_EN
    logic [31:0] perf_mul_defer_cycles;
    logic [31:0] perf_retired;
    logic [31:0] perf_fifo_full_cycles;
`endif

    // Environment side: drives results and issue, observes writeback
    modport master (
        output alu_valid, alu_wb_inf, mul_valid, mul_wb_inf, ix_mul_issue,
        input  ix_mul_ready, rf_we, rf_waddr, rf_wdata,
        input  wb_retire_valid, wb_retire_rd
`ifdef WB_PERF_COUNTERS_EN
        , input perf_mul_defer_cycles, perf_retired, perf_fifo_full_cycles
`endif
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_wb_inf, mul_valid, mul_wb_inf, ix_mul_issue,
        output ix_mul_ready, rf_we, rf_waddr, rf_wdata,
        output wb_retire_valid, wb_retire_rd
`ifdef WB_PERF_COUNTERS_EN
        , output perf_mul_defer_cycles, perf_retired, perf_fifo_full_cycles
`endif
    );

endinterface

// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: merges ALU and MUL results onto one register-file
// write port. ALU always wins; MUL results that lose are held in a skid FIFO
// and retire in arrival order. An inflight credit counter keeps IX from
// launching a MUL op the FIFO could not absorb.
// Optional perf counters are built when WB_PERF_COUNTERS_EN is defined.
module wb_commit_arbiter #(
    parameter int unsigned MUL_FIFO_DEPTH = 4,
    parameter int unsigned MUL_PIPE_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    wb_commit_arbiter_if.slave  bus
);

    localparam int unsigned AW = $clog2(MUL_FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    // Inflight is bounded by the FIFO depth through the credit check, but is
    // sized to also cover a full MUL pipe so a misbehaving IX cannot wrap it.
    localparam int unsigned IW = $clog2(MUL_FIFO_DEPTH + MUL_PIPE_DEPTH + 1);
    localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;
    localparam int unsigned DW = 37;

    // FIFO state
    logic [DW-1:0] r_mem [MUL_FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_inflight;

    // Registered writeback outputs
    logic          r_rf_we;
    logic [4:0]    r_rf_waddr;
    logic [31:0]   r_rf_wdata;
    logic          r_retire_valid;
    logic [4:0]    r_retire_rd;

    // Arbitration and FIFO control
    logic          w_empty;
    logic          w_full;
    logic          w_sel_byp;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ready;
    logic          w_issue;
    logic          w_mul_ret;
    logic [DW-1:0] w_head;
    logic          w_ret_v;
    logic [4:0]    w_ret_rd;
    logic [31:0]   w_ret_data;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(MUL_FIFO_DEPTH));
    assign w_head     = r_mem[r_rd_ptr];

    assign w_pop      = !bus.alu_valid && !w_empty;
    assign w_sel_byp  = !bus.alu_valid && w_empty && bus.mul_valid;
    assign w_push_req = bus.mul_valid && !w_sel_byp;
    // A push into a full FIFO is only legal alongside a pop; otherwise drop it.
    assign w_push     = w_push_req && (!w_full || w_pop);

    assign w_ready    = !rst &&
                        ((SW'(r_count) + SW'(r_inflight) + SW'(1)) <= SW'(MUL_FIFO_DEPTH));
    assign w_issue    = bus.ix_mul_issue && w_ready;
    assign w_mul_ret  = bus.mul_valid && (r_inflight != '0);

    // Select this cycle's retiring result: ALU, then FIFO head, then bypass
    always_comb begin
        w_ret_v    = 1'b0;
        w_ret_rd   = '0;
        w_ret_data = '0;
        if (bus.alu_valid) begin
            w_ret_v    = 1'b1;
            w_ret_rd   = bus.alu_wb_inf.rd;
            w_ret_data = bus.alu_wb_inf.result;
        end else if (!w_empty) begin
            w_ret_v    = 1'b1;
            w_ret_rd   = w_head[36:32];
            w_ret_data = w_head[31:0];
        end else if (bus.mul_valid) begin
            w_ret_v    = 1'b1;
            w_ret_rd   = bus.mul_wb_inf.rd;
            w_ret_data = bus.mul_wb_inf.result;
        end
    end

    // FIFO storage; contents are not reset, pointers and count qualify them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.mul_wb_inf;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Inflight MUL credit tracking: +1 on accepted issue, -1 on MUL result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (w_issue && !w_mul_ret) begin
            r_inflight <= r_inflight + IW'(1);
        end else if (w_mul_ret && !w_issue) begin
            r_inflight <= r_inflight - IW'(1);
        end
    end

    // Register the winning result onto the write port and retire bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_retire_valid <= 1'b0;
            r_retire_rd    <= '0;
        end else begin
            r_rf_we        <= w_ret_v && (w_ret_rd != 5'd0);
            r_retire_valid <= w_ret_v;
            if (w_ret_v) begin
                r_rf_waddr  <= w_ret_rd;
                r_rf_wdata  <= w_ret_data;
                r_retire_rd <= w_ret_rd;
            end
        end
    end

    assign bus.ix_mul_ready    = w_ready;
    assign bus.rf_we           = r_rf_we;
    assign bus.rf_waddr        = r_rf_waddr;
    assign bus.rf_wdata        = r_rf_wdata;
    assign bus.wb_retire_valid = r_retire_valid;
    assign bus.wb_retire_rd    = r_retire_rd;

`ifdef WB_PERF_COUNTERS_EN
    logic [31:0] r_perf_defer;
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_full;

    // Performance counters, free-running and wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_defer   <= '0;
            r_perf_retired <= '0;
            r_perf_full    <= '0;
        end else begin
            if (!w_empty && bus.alu_valid) begin
                r_perf_defer <= r_perf_defer + 32'd1;
            end
            if (r_retire_valid) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (w_full) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
        end
    end

    assign bus.perf_mul_defer_cycles = r_perf_defer;
    assign bus.perf_retired          = r_perf_retired;
    assign bus.perf_fifo_full_cycles = r_perf_full;
`endif

`ifndef SYNTHESIS
    // A compliant IX never lets a MUL result arrive at a full, non-draining FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push_req && w_full && !w_pop))
        else $error("wb_commit_arbiter: MUL result dropped on full FIFO");
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: a vector table of per-cycle
// inputs with hand-derived expected retirements, plus hand-written credit and
// mid-operation reset sequences.
module tb_wb_commit_arbiter;

    typedef struct packed {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        mul_v;
        logic [4:0]  mul_rd;
        logic [31:0] mul_d;
        logic        issue;
        logic        exp_rdy;
        logic        exp_v;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t tbl[15];

    wb_commit_arbiter_if bus();

    wb_commit_arbiter #(
        .MUL_FIFO_DEPTH(4),
        .MUL_PIPE_DEPTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic iss, input logic er,
                                input logic ev, input logic [4:0] erd, input logic [31:0] ed);
        vec_t r;
        r.alu_v = av;  r.alu_rd = ard; r.alu_d = ad;
        r.mul_v = mv;  r.mul_rd = mrd; r.mul_d = md;
        r.issue = iss; r.exp_rdy = er;
        r.exp_v = ev;  r.exp_rd = erd; r.exp_d = ed;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.alu_valid    = 1'b0;
        bus.alu_wb_inf   = '0;
        bus.mul_valid    = 1'b0;
        bus.mul_wb_inf   = '0;
        bus.ix_mul_issue = 1'b0;
    endtask

    // Apply one cycle of stimulus; the expected retirement goes to the
    // scoreboard and is compared once the registered outputs update.
    task automatic run_vec(input string tag, input vec_t v);
        exp_t e;
        bus.alu_valid         = v.alu_v;
        bus.alu_wb_inf.rd     = v.alu_rd;
        bus.alu_wb_inf.result = v.alu_d;
        bus.mul_valid         = v.mul_v;
        bus.mul_wb_inf.rd     = v.mul_rd;
        bus.mul_wb_inf.result = v.mul_d;
        bus.ix_mul_issue      = v.issue;
        sb.push_back({v.exp_v, v.exp_rd, v.exp_d});
        chk({tag, ".ready"}, 32'(bus.ix_mul_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        drive_idle();
        e = sb.pop_front();
        chk({tag, ".retire_valid"}, 32'(bus.wb_retire_valid), 32'(e.v));
        chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(e.v && (e.rd != 5'd0)));
        if (e.v) begin
            chk({tag, ".retire_rd"}, 32'(bus.wb_retire_rd), 32'(e.rd));
            chk({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e.rd));
            if (e.rd != 5'd0) begin
                chk({tag, ".rf_wdata"}, bus.rf_wdata, e.d);
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t cs[11];
        vec_t rs[2];
`ifdef WB_PERF_COUNTERS_EN
        logic [31:0] perf_before;
`endif
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive_idle();

        // Main table: bypass, ALU/MUL conflict, pressure ordering, full
        // pop+push, x0 retire. Expected ready follows fifo_count alone.
        tbl[0]  = mk(0, 0, 0,       1, 5, 32'h0000_1234, 0, 1, 1, 5, 32'h0000_1234);
        tbl[1]  = mk(1, 3, 32'hA,   1, 7, 32'hB,         0, 1, 1, 3, 32'hA);
        tbl[2]  = mk(0, 0, 0,       0, 0, 0,             0, 1, 1, 7, 32'hB);
        tbl[3]  = mk(0, 0, 0,       0, 0, 0,             0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 10, 32'h100, 1, 1, 32'h201,      0, 1, 1, 10, 32'h100);
        tbl[5]  = mk(1, 11, 32'h101, 1, 2, 32'h202,      0, 1, 1, 11, 32'h101);
        tbl[6]  = mk(1, 12, 32'h102, 1, 3, 32'h203,      0, 1, 1, 12, 32'h102);
        tbl[7]  = mk(1, 13, 32'h103, 1, 4, 32'h204,      0, 1, 1, 13, 32'h103);
        tbl[8]  = mk(0, 0, 0,       1, 20, 32'h300,      0, 0, 1, 1, 32'h201);
        tbl[9]  = mk(0, 0, 0,       0, 0, 0,             0, 0, 1, 2, 32'h202);
        tbl[10] = mk(0, 0, 0,       0, 0, 0,             0, 1, 1, 3, 32'h203);
        tbl[11] = mk(0, 0, 0,       0, 0, 0,             0, 1, 1, 4, 32'h204);
        tbl[12] = mk(0, 0, 0,       0, 0, 0,             0, 1, 1, 20, 32'h300);
        tbl[13] = mk(0, 0, 0,       1, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 32'hFFFF_FFFF);
        tbl[14] = mk(0, 0, 0,       0, 0, 0,             0, 1, 0, 0, 0);

        // Credit: four issues exhaust credits; a FIFO push keeps them
        // exhausted, the pop frees one, bypassed results free the rest.
        cs[0]  = mk(0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0);
        cs[1]  = mk(0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0);
        cs[2]  = mk(0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0);
        cs[3]  = mk(0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0);
        cs[4]  = mk(0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0);
        cs[5]  = mk(1, 9, 32'h99,  1, 6, 32'h66,  0, 0, 1, 9, 32'h99);
        cs[6]  = mk(0, 0, 0,       0, 0, 0,       0, 0, 1, 6, 32'h66);
        cs[7]  = mk(0, 0, 0,       1, 21, 32'h21, 0, 1, 1, 21, 32'h21);
        cs[8]  = mk(0, 0, 0,       1, 22, 32'h22, 0, 1, 1, 22, 32'h22);
        cs[9]  = mk(0, 0, 0,       1, 23, 32'h23, 0, 1, 1, 23, 32'h23);
        cs[10] = mk(0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0);

        // Queue two MUL results behind ALU traffic before the mid-run reset
        rs[0] = mk(1, 10, 32'h1, 1, 1, 32'hDEAD_0001, 0, 1, 1, 10, 32'h1);
        rs[1] = mk(1, 11, 32'h2, 1, 2, 32'hDEAD_0002, 0, 1, 1, 11, 32'h2);

        // Power-on reset state
        #1;
        chk("por.rf_we", 32'(bus.rf_we), 32'd0);
        chk("por.retire_valid", 32'(bus.wb_retire_valid), 32'd0);
        chk("por.ready_in_reset", 32'(bus.ix_mul_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("por.ready_after", 32'(bus.ix_mul_ready), 32'd1);
        chk("por.rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("por.rf_wdata", bus.rf_wdata, 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        for (int i = 0; i < 11; i++) begin
            run_vec($sformatf("credit%0d", i), cs[i]);
        end

        // Mid-operation reset with two entries queued
        for (int i = 0; i < 2; i++) begin
            run_vec($sformatf("rstq%0d", i), rs[i]);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst.retire_valid", 32'(bus.wb_retire_valid), 32'd0);
        chk("midrst.ready", 32'(bus.ix_mul_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.held_retire", 32'(bus.wb_retire_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst.ready_after", 32'(bus.ix_mul_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("postrst%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end

`ifdef WB_PERF_COUNTERS_EN
        perf_before = bus.perf_retired;
        run_vec("perf.x0", mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 32'hFFFF_FFFF));
        run_vec("perf.idle", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        chk("perf.retired_x0", bus.perf_retired, perf_before + 32'd1);
`endif

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
